// File: rtl/sound_pkg.sv
// Shared constants for the sound scheduler: default widths, sound indices,
// the sound ROM start/end address map and the playback state encoding.
package sound_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 6;
  localparam int DIV_W      = 11;
  localparam int NUM_SOUNDS = 4;

  localparam logic [1:0] WIN    = 2'd0;
  localparam logic [1:0] CHEER  = 2'd1;
  localparam logic [1:0] DETECT = 2'd2;
  localparam logic [1:0] MOO    = 2'd3;

  typedef logic [NUM_SOUNDS-1:0][ADDR_W_DEF-1:0] addr_tbl_t;

  // Element 0 is the win sound; the literal lists moo, detect, cheer, win.
  localparam addr_tbl_t START_TBL = {18'd16396, 18'd66983, 18'd83255, 18'd0};
  localparam addr_tbl_t END_TBL   = {18'd66982, 18'd83254, 18'd137138, 18'd16395};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

endpackage

// File: rtl/sound_scheduler_if.sv
// Request/ROM/audio bundle between the sound scheduler (slave) and its
// surroundings: request sources, the shared sound ROM and the audio codec.
interface sound_scheduler_if
  import sound_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [NUM_SOUNDS-1:0] sound_req;
  logic                  stop;
  logic [ADDR_W-1:0]     rom_addr;
  logic [DATA_W-1:0]     rom_q;
  logic [31:0]           audio_left;
  logic                  sample_valid;
  logic                  busy;
  logic [1:0]            playing_id;
  logic                  sound_done;

  modport master (
    output sound_req, stop, rom_q,
    input  rom_addr, audio_left, sample_valid, busy, playing_id, sound_done
  );

  modport slave (
    input  sound_req, stop, rom_q,
    output rom_addr, audio_left, sample_valid, busy, playing_id, sound_done
  );

endinterface

// File: rtl/sound_prio_enc.sv
// Fixed-priority picker over the pending sounds; bit 0 has the highest
// priority.
module sound_prio_enc (
  input  logic [3:0] i_req,
  output logic       o_valid,
  output logic [1:0] o_idx
);

  always_comb begin
    o_valid = |i_req;
    o_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = 2'(i);
      end
    end
  end

endmodule

// File: rtl/sound_scheduler.sv
// Queues sound requests, plays one sound at a time from the shared ROM and
// streams one sample every SAMPLE_DIV clocks to the audio codec.
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int SAMPLE_DIV = 1200,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter logic [NUM_SOUNDS-1:0][ADDR_W-1:0] START_ADDR = START_TBL,
  parameter logic [NUM_SOUNDS-1:0][ADDR_W-1:0] END_ADDR   = END_TBL
) (
  input logic              CLOCK_50,
  input logic              reset,
  sound_scheduler_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [NUM_SOUNDS-1:0] r_pending;
  logic [1:0]            r_playing_id;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [ADDR_W-1:0]     r_rom_addr;
  logic [DATA_W-1:0]     r_sample;
  logic                  r_sample_valid;
  logic                  r_sound_done;

  logic                  w_grant_valid;
  logic [1:0]            w_grant_idx;
  logic                  w_grant;
  logic                  w_finish;
  logic [NUM_SOUNDS-1:0] w_clear_mask;
  logic                  w_div_last;
  logic                  w_at_end;
  logic                  w_capture;

  sound_prio_enc u_prio (
    .i_req   (r_pending),
    .o_valid (w_grant_valid),
    .o_idx   (w_grant_idx)
  );

  assign w_div_last = (r_div_cnt == DIV_LAST);
  assign w_at_end   = (r_rom_addr == END_ADDR[r_playing_id]);
  assign w_capture  = (r_state == ST_PLAY) && (r_div_cnt == DIV_W'(1));

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_next_state = ST_LOAD;
          w_grant      = 1'b1;
        end
      end
      ST_LOAD: w_next_state = ST_PLAY;
      ST_PLAY: begin
        if (w_div_last && w_at_end) begin
          w_next_state = ST_IDLE;
          w_finish     = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    // stop overrides everything, including a grant in the same cycle
    if (bus.stop) begin
      w_next_state = ST_IDLE;
      w_grant      = 1'b0;
      w_finish     = 1'b0;
    end
    w_clear_mask = w_grant ? (NUM_SOUNDS'(1) << w_grant_idx) : '0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A request arriving on the grant cycle re-arms its own pending bit.
  always_ff @(posedge CLOCK_50) begin
    if (reset || bus.stop) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clear_mask) | bus.sound_req;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_playing_id   <= 2'd0;
      r_div_cnt      <= '0;
      r_rom_addr     <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_sound_done   <= 1'b0;
    end else if (bus.stop) begin
      r_div_cnt      <= '0;
      r_rom_addr     <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_sound_done   <= 1'b0;
    end else begin
      r_sample_valid <= w_capture;
      r_sound_done   <= w_finish;
      if (w_grant) begin
        r_playing_id <= w_grant_idx;
      end
      if (r_state == ST_LOAD) begin
        r_rom_addr <= START_ADDR[r_playing_id];
        r_div_cnt  <= '0;
      end else if (r_state == ST_PLAY) begin
        if (w_capture) begin
          r_sample <= bus.rom_q;
        end
        r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
        if (w_div_last && !w_at_end) begin
          r_rom_addr <= r_rom_addr + 1'b1;
        end
      end
    end
  end

  assign bus.rom_addr     = r_rom_addr;
  assign bus.audio_left   = {r_sample, {(32 - DATA_W){1'b0}}};
  assign bus.sample_valid = r_sample_valid;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.playing_id   = r_playing_id;
  assign bus.sound_done   = r_sound_done;

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler with a small address map and a ROM
// model returning addr[5:0]; a scoreboard checks every sample and completion.
module tb_sound_scheduler;
  import sound_pkg::*;

  localparam int SAMPLE_DIV = 4;
  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 6;
  localparam logic [3:0][17:0] TB_START = {18'd10, 18'd30, 18'd40, 18'd0};
  localparam logic [3:0][17:0] TB_END   = {18'd20, 18'd33, 18'd40, 18'd5};

  typedef struct {
    logic [31:0] audio;
    logic [1:0]  id;
    bit          first;
  } expSample_t;

  logic CLOCK_50;
  logic reset;
  int   assertCount = 0;
  int   failCount = 0;
  int   cycleCount = 0;
  int   lastSampleCycle = 0;
  expSample_t  sampleQ[$];
  logic [1:0]  doneQ[$];
  expSample_t  monSample;
  logic [1:0]  monDoneId;

  sound_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sound_scheduler #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .START_ADDR (TB_START),
    .END_ADDR   (TB_END)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    bus.rom_q  <= bus.rom_addr[5:0];
    cycleCount <= cycleCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pushSound(input logic [1:0] id);
    logic [17:0] addr;
    for (int a = int'(TB_START[id]); a <= int'(TB_END[id]); a++) begin
      addr = 18'(a);
      sampleQ.push_back('{audio: {addr[5:0], 26'd0}, id: id, first: (a == int'(TB_START[id]))});
    end
    doneQ.push_back(id);
  endtask

  // Called at posedge+1; holds the inputs for exactly one clock edge.
  task automatic applyStimulus(input logic [3:0] req, input logic stp);
    bus.sound_req = req;
    bus.stop      = stp;
    @(posedge CLOCK_50);
    #1;
    bus.sound_req = 4'd0;
    bus.stop      = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic waitDone(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLOCK_50);
      #1;
      if (bus.sound_done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  // Scoreboard side: every sample/completion must match the head of its queue.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (bus.sample_valid) begin
        checkOutput("sample_expected", 32'(sampleQ.size() != 0), 32'd1);
        if (sampleQ.size() != 0) begin
          monSample = sampleQ.pop_front();
          checkOutput("audio_left", bus.audio_left, monSample.audio);
          checkOutput("sample_id", 32'(bus.playing_id), 32'(monSample.id));
          if (!monSample.first) begin
            checkOutput("sample_gap", 32'(cycleCount - lastSampleCycle), 32'(SAMPLE_DIV));
          end
        end
        lastSampleCycle = cycleCount;
      end
      if (bus.sound_done) begin
        checkOutput("done_expected", 32'(doneQ.size() != 0), 32'd1);
        if (doneQ.size() != 0) begin
          monDoneId = doneQ.pop_front();
          checkOutput("done_id", 32'(bus.playing_id), 32'(monDoneId));
          checkOutput("done_gap", 32'(cycleCount - lastSampleCycle), 32'd2);
        end
      end
    end
  end

  initial begin
    bit sawBusy;

    reset         = 1'b1;
    bus.sound_req = 4'd0;
    bus.stop      = 1'b0;
    waitCycles(3);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    checkOutput("rst_audio", bus.audio_left, 32'd0);
    checkOutput("rst_id", 32'(bus.playing_id), 32'd0);
    checkOutput("rst_valid", 32'(bus.sample_valid), 32'd0);
    checkOutput("rst_done", 32'(bus.sound_done), 32'd0);
    reset = 1'b0;
    waitCycles(2);

    $display("[TB] single win request");
    pushSound(WIN);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("t1_busy_pre", 32'(bus.busy), 32'd0);
    waitCycles(1);
    checkOutput("t1_busy_rise", 32'(bus.busy), 32'd1);
    checkOutput("t1_id", 32'(bus.playing_id), 32'(WIN));
    waitCycles(1);
    checkOutput("t1_load_addr", 32'(bus.rom_addr), 32'd0);
    waitDone("t1_done_timeout", 200);
    checkOutput("t1_busy_end", 32'(bus.busy), 32'd0);
    waitCycles(5);
    checkOutput("t1_audio_hold", bus.audio_left, {6'd5, 26'd0});
    checkOutput("t1_idle", 32'(bus.busy), 32'd0);

    $display("[TB] simultaneous cheer and moo");
    pushSound(CHEER);
    pushSound(MOO);
    applyStimulus(4'b1010, 1'b0);
    waitDone("t2_cheer_timeout", 200);
    waitDone("t2_moo_timeout", 200);
    checkOutput("t2_busy_end", 32'(bus.busy), 32'd0);
    waitCycles(5);
    checkOutput("t2_pending_empty", 32'(bus.busy), 32'd0);

    $display("[TB] queued win during detect");
    pushSound(DETECT);
    applyStimulus(4'b0100, 1'b0);
    waitCycles(10);
    pushSound(WIN);
    applyStimulus(4'b0001, 1'b0);
    waitDone("t3_detect_timeout", 200);
    waitCycles(1);
    checkOutput("t3_grant_busy", 32'(bus.busy), 32'd1);
    checkOutput("t3_grant_id", 32'(bus.playing_id), 32'(WIN));
    checkOutput("t3_addr_hold", 32'(bus.rom_addr), 32'd33);
    waitCycles(1);
    checkOutput("t3_win_addr", 32'(bus.rom_addr), 32'd0);
    waitDone("t3_win_timeout", 200);

    $display("[TB] reset during cheer");
    pushSound(CHEER);
    applyStimulus(4'b0010, 1'b0);
    waitCycles(2);
    checkOutput("t5_playing", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    waitCycles(1);
    sampleQ.delete();
    doneQ.delete();
    checkOutput("t5_busy", 32'(bus.busy), 32'd0);
    checkOutput("t5_rom_addr", 32'(bus.rom_addr), 32'd0);
    checkOutput("t5_audio", bus.audio_left, 32'd0);
    checkOutput("t5_id", 32'(bus.playing_id), 32'd0);
    checkOutput("t5_valid", 32'(bus.sample_valid), 32'd0);
    checkOutput("t5_done", 32'(bus.sound_done), 32'd0);
    reset = 1'b0;
    waitCycles(2);

    $display("[TB] stop during moo with win pending");
    pushSound(MOO);
    applyStimulus(4'b1000, 1'b0);
    sawBusy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.rom_addr == 18'd15) begin
        sawBusy = 1'b1;
        break;
      end
      waitCycles(1);
    end
    checkOutput("t4_reach_addr", 32'(sawBusy), 32'd1);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    sampleQ.delete();
    doneQ.delete();
    checkOutput("t4_busy", 32'(bus.busy), 32'd0);
    checkOutput("t4_rom_addr", 32'(bus.rom_addr), 32'd0);
    checkOutput("t4_audio", bus.audio_left, 32'd0);
    sawBusy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      waitCycles(1);
      if (bus.busy || bus.sound_done) sawBusy = 1'b1;
    end
    checkOutput("t4_no_win", 32'(sawBusy), 32'd0);

    $display("[TB] stop and request collide");
    applyStimulus(4'b0100, 1'b1);
    sawBusy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy) sawBusy = 1'b1;
      waitCycles(1);
    end
    checkOutput("t6_busy_low", 32'(sawBusy), 32'd0);

    checkOutput("sample_queue_empty", 32'(sampleQ.size()), 32'd0);
    checkOutput("done_queue_empty", 32'(doneQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
